gsau_sequencer: RTL and testbench
=================================

// Module: gsau_sequencer
// PURPOSE
//  Controller between the veggie file / scoreboard and the systolic array inside the GSAU.
//  Sequences weight loading and activation streaming.
//  Tags each issued activation with its vdst, matches array outputs to tags in order,
//  and buffers results for the WB buffer.
//  Credit flow control ensures array outputs never need to be stalled.
// PARAMETERS
//  DW     512  vector / array data width (bits)
//  TAGW   8    destination register tag width
//  WROWS  4    weight vectors per weight load (array rows)
//  DEPTH  4    max results in flight + buffered (tag FIFO and output buffer depth)
// PORTS
//  CLK                input   1     clock
//  nRST               input   1     async active-low reset
//  vdata              input   DW    vector from veggie file
//  valid              input   1     vdata valid
//  weight             input   1     1 = vdata is a weight row, 0 = activation
//  nvdst              input   TAGW  destination reg for an activation
//  ready              output  1     vector accepted this cycle when valid&ready
//  svalid             output  1     scoreboard: activation issued (1-cycle pulse)
//  vdst               output  TAGW  scoreboard: tag of issued activation
//  array_in           output  DW    data to systolic array
//  array_in_partials  output  DW    partial-sum input; tied 0 this revision
//  input_en           output  1     array_in is an activation
//  weight_en          output  1     array_in is a weight row
//  partial_en         output  1     tied 0 this revision
//  array_output       input   DW    result row from array
//  out_en             input   1     array_output valid (cannot be stalled)
//  fifo_has_space     input   1     array input FIFO can take an activation
//  psum               output  DW    head result to WB buffer
//  wbdst              output  TAGW  head result tag
//  wb_valid           output  1     output buffer non-empty
//  output_ready       input   1     WB buffer accepts psum
//  err                output  1     sticky: out_en seen with empty tag FIFO
// BEHAVIOUR
//  Reset
//   - Every output is 0 (ready is then combinational per state).
//   - State LOAD_W, wcnt=0, tag FIFO and output buffer empty, err=0.
//  State machine
//   - LOAD_W: ready = weight.
//       Each valid&weight handshake increments wcnt.
//       On the WROWS-th handshake: wcnt<=0, go to STREAM.
//       Activations offered in LOAD_W are held off (ready=0).
//   - STREAM, activation: ready = fifo_has_space & (tcnt+ocnt < DEPTH).
//   - STREAM, weight: ready=0 and go to DRAIN; the weight is not consumed.
//   - DRAIN: ready=0 until tcnt==0 (all issued activations returned), then go to LOAD_W.
//       Buffered outputs need not be drained first.
//  Issue (registered, 1-cycle latency)
//   - A handshake in cycle N drives array_in=vdata in cycle N+1, with weight_en or input_en =1
//     for exactly that one cycle.
//   - Activations also drive svalid=1 and vdst=nvdst in cycle N+1.
//   - Activations push nvdst into the tag FIFO in cycle N (tcnt++).
//  Return
//   - On out_en: pop the tag FIFO head and push {array_output, tag} into the output buffer.
//     Net tcnt--, ocnt++, occupancy unchanged.
//   - out_en with tcnt==0: result dropped, err<=1 (cleared only by reset).
//   - Results return in issue order.
//  Writeback
//   - Output buffer is first-word-fall-through: wb_valid = ocnt!=0; psum/wbdst = head.
//   - Pop on wb_valid & output_ready.
//   - Push and pop in the same cycle: ocnt unchanged, data ordering preserved.
//  Credit: tcnt+ocnt <= DEPTH always, so the output buffer never overflows on out_en.
//  Counters are sized $clog2(DEPTH+1); FIFO pointers wrap modulo DEPTH.
//  Handshake: once valid is raised, vdata/weight/nvdst are held stable until ready.
//  nRST low mid-operation: everything returns to reset values; in-flight tags are discarded.
// TESTING
//  1. Reset, valid=1, weight=1 -> ready=1, all other outputs 0, err=0.
//  2. Four weight handshakes (WROWS=4) -> four weight_en pulses, one cycle after each
//     handshake; first activation (nvdst=3) then accepted -> input_en and svalid,
//     vdst=3, one cycle later.
//  3. STREAM with output_ready=0: activations with tags 3,7,9,12 accepted and a fifth held
//     (ready=0); four out_en pulses -> ocnt=4.
//     Then output_ready=1 -> wbdst 3,7,9,12 in order, with matching psum.
//  4. Weight offered with 2 in flight -> ready=0 in DRAIN; after the 2nd out_en the FSM
//     enters LOAD_W and that weight is accepted next cycle.
//  5. fifo_has_space=0 with activation valid -> ready=0, no input_en;
//     raising fifo_has_space -> accepted the same cycle.
//  6. out_en with empty tag FIFO -> err=1 (sticky), wb_valid stays 0;
//     nRST pulse -> err=0.

Source files
------------

// File: rtl/gsau_sequencer.sv
// GSAU sequencer: loads WROWS weight rows, then streams tagged activations into the systolic array.
// Issue latency 1 cycle; returned results are buffered FWFT and presented to the WB buffer with 0-cycle latency.
// Backpressure: input held off by credit (tags in flight + buffered <= DEPTH); array outputs are never stalled.

module gsau_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_dat,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; callers never push when full or pop when empty.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (i_pop) r_rptr <= ptr_inc(r_rptr);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head = r_mem[r_rptr];
  assign o_cnt  = r_cnt;
endmodule

module gsau_sequencer #(
  parameter int DW    = 512,
  parameter int TAGW  = 8,
  parameter int WROWS = 4,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [DW-1:0]   vdata,
  input  logic            valid,
  input  logic            weight,
  input  logic [TAGW-1:0] nvdst,
  output logic            ready,
  output logic            svalid,
  output logic [TAGW-1:0] vdst,
  output logic [DW-1:0]   array_in,
  output logic [DW-1:0]   array_in_partials,
  output logic            input_en,
  output logic            weight_en,
  output logic            partial_en,
  input  logic [DW-1:0]   array_output,
  input  logic            out_en,
  input  logic            fifo_has_space,
  output logic [DW-1:0]   psum,
  output logic [TAGW-1:0] wbdst,
  output logic            wb_valid,
  input  logic            output_ready,
  output logic            err
);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int WCW = (WROWS > 1) ? $clog2(WROWS) : 1;

  typedef enum logic [1:0] {S_LOAD_W, S_STREAM, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WCW-1:0]    r_wcnt;
  logic [CW-1:0]     w_tcnt;
  logic [CW-1:0]     w_ocnt;
  logic [CW:0]       w_occ;
  logic              w_hs;
  logic              w_act_hs;
  logic              w_wgt_hs;
  logic              w_ret;
  logic              w_wb_pop;
  logic              w_last_row;
  logic [TAGW-1:0]   w_tag_head;
  logic [DW+TAGW-1:0] w_ob_head;
  logic              r_svalid;
  logic              r_input_en;
  logic              r_weight_en;
  logic [TAGW-1:0]   r_vdst;
  logic [DW-1:0]     r_array_in;
  logic              r_err;

  assign w_hs       = valid & ready;
  assign w_act_hs   = w_hs & ~weight;
  assign w_wgt_hs   = w_hs & weight;
  assign w_ret      = out_en & (w_tcnt != '0);
  assign w_wb_pop   = wb_valid & output_ready;
  assign w_occ      = {1'b0, w_tcnt} + {1'b0, w_ocnt};
  assign w_last_row = (r_wcnt == WCW'(WROWS-1));

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_LOAD_W;
    else       r_state <= w_next;
  end

  // FSM next state: weights until the last row, stream until a weight shows up, drain until tags return.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD_W: if (w_wgt_hs && w_last_row) w_next = S_STREAM;
      S_STREAM: if (valid && weight)        w_next = S_DRAIN;
      S_DRAIN:  if (w_tcnt == '0)           w_next = S_LOAD_W;
      default:                              w_next = S_LOAD_W;
    endcase
  end

  // FSM outputs: ready per state; activations also need array FIFO space and a result credit.
  always_comb begin
    ready = 1'b0;
    case (r_state)
      S_LOAD_W: ready = weight;
      S_STREAM: ready = ~weight & fifo_has_space & (w_occ < (CW+1)'(DEPTH));
      default:  ready = 1'b0;
    endcase
  end

  // Weight row counter within one load.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)         r_wcnt <= '0;
    else if (w_wgt_hs) r_wcnt <= w_last_row ? '0 : r_wcnt + 1'b1;
  end

  // Issue stage: one-cycle pulse towards the array and the scoreboard after each handshake.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_svalid    <= 1'b0;
      r_input_en  <= 1'b0;
      r_weight_en <= 1'b0;
      r_vdst      <= '0;
      r_array_in  <= '0;
    end else begin
      r_svalid    <= w_act_hs;
      r_input_en  <= w_act_hs;
      r_weight_en <= w_wgt_hs;
      if (w_hs)     r_array_in <= vdata;
      if (w_act_hs) r_vdst     <= nvdst;
    end
  end

  // Sticky error: a result arrived with no tag outstanding.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                       r_err <= 1'b0;
    else if (out_en && w_tcnt == '0) r_err <= 1'b1;
  end

  gsau_fifo #(.W(TAGW), .DEPTH(DEPTH)) u_tag_fifo (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_push     (w_act_hs),
    .i_push_dat (nvdst),
    .i_pop      (w_ret),
    .o_head     (w_tag_head),
    .o_cnt      (w_tcnt)
  );

  gsau_fifo #(.W(DW+TAGW), .DEPTH(DEPTH)) u_out_buf (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_push     (w_ret),
    .i_push_dat ({array_output, w_tag_head}),
    .i_pop      (w_wb_pop),
    .o_head     (w_ob_head),
    .o_cnt      (w_ocnt)
  );

  assign svalid            = r_svalid;
  assign vdst              = r_vdst;
  assign array_in          = r_array_in;
  assign input_en          = r_input_en;
  assign weight_en         = r_weight_en;
  assign array_in_partials = '0;
  assign partial_en        = 1'b0;
  assign wb_valid          = (w_ocnt != '0);
  assign psum              = w_ob_head[DW+TAGW-1:TAGW];
  assign wbdst             = w_ob_head[TAGW-1:0];
  assign err               = r_err;
endmodule

// File: tb/tb_gsau_sequencer.sv
// Bench for gsau_sequencer: directed scenarios then random traffic against a queue-based model.
// Model expectations are recomputed every cycle; outputs sampled 1ns after the falling edge.
// Inputs change on the falling edge and respect the hold-until-ready handshake rule.

module tb_gsau_sequencer;
  localparam int DW    = 512;
  localparam int TAGW  = 8;
  localparam int WROWS = 4;
  localparam int DEPTH = 4;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [DW-1:0]   vdata;
  logic            valid;
  logic            weight;
  logic [TAGW-1:0] nvdst;
  logic            ready;
  logic            svalid;
  logic [TAGW-1:0] vdst;
  logic [DW-1:0]   array_in;
  logic [DW-1:0]   array_in_partials;
  logic            input_en;
  logic            weight_en;
  logic            partial_en;
  logic [DW-1:0]   array_output;
  logic            out_en;
  logic            fifo_has_space;
  logic [DW-1:0]   psum;
  logic [TAGW-1:0] wbdst;
  logic            wb_valid;
  logic            output_ready;
  logic            err;

  gsau_sequencer #(.DW(DW), .TAGW(TAGW), .WROWS(WROWS), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .vdata(vdata), .valid(valid), .weight(weight), .nvdst(nvdst),
    .ready(ready), .svalid(svalid), .vdst(vdst), .array_in(array_in),
    .array_in_partials(array_in_partials), .input_en(input_en), .weight_en(weight_en),
    .partial_en(partial_en), .array_output(array_output), .out_en(out_en),
    .fifo_has_space(fifo_has_space), .psum(psum), .wbdst(wbdst), .wb_valid(wb_valid),
    .output_ready(output_ready), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: phase 0 = loading weights, 1 = streaming, 2 = draining.
  int                  ph;
  int                  wc;
  logic [TAGW-1:0]     tq[$];
  logic [DW+TAGW-1:0]  oq[$];
  bit                  m_err;
  bit                  e_wen, e_ien, last_hs;
  logic [TAGW-1:0]     e_vdst;
  logic [DW-1:0]       e_dat;

  function automatic bit m_ready();
    case (ph)
      0:       return weight;
      1:       return !weight && fifo_has_space && (tq.size() + oq.size() < DEPTH);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    ph = 0; wc = 0; tq.delete(); oq.delete(); m_err = 0;
    e_wen = 0; e_ien = 0; e_vdst = '0; e_dat = '0; last_hs = 0;
  endtask

  task automatic check_outs(input bit full);
    logic [DW+TAGW-1:0] hd;
    hd = (oq.size() != 0) ? oq[0] : '0;
    chk("ready", DW'(ready), DW'(m_ready()));
    chk("weight_en", DW'(weight_en), DW'(e_wen));
    chk("input_en", DW'(input_en), DW'(e_ien));
    chk("svalid", DW'(svalid), DW'(e_ien));
    chk("wb_valid", DW'(wb_valid), DW'(oq.size() != 0));
    chk("err", DW'(err), DW'(m_err));
    chk("partial_en", DW'(partial_en), '0);
    chk("array_in_partials", array_in_partials, '0);
    if (e_wen || e_ien || full) chk("array_in", array_in, e_dat);
    if (e_ien || full)          chk("vdst", DW'(vdst), DW'(e_vdst));
    if (oq.size() != 0 || full) begin
      chk("wbdst", DW'(wbdst), DW'(hd[TAGW-1:0]));
      chk("psum", psum, hd[DW+TAGW-1:TAGW]);
    end
  endtask

  // One clock: check, advance the model by the spec rules, wait for the next falling edge.
  task automatic step();
    bit hs;
    int tsz;
    #1;
    check_outs(1'b0);
    hs  = valid && m_ready();
    tsz = tq.size();
    if (oq.size() != 0 && output_ready) void'(oq.pop_front());
    if (out_en) begin
      if (tq.size() != 0) oq.push_back({array_output, tq.pop_front()});
      else                m_err = 1;
    end
    if (hs && !weight) tq.push_back(nvdst);
    e_wen = hs && weight;
    e_ien = hs && !weight;
    if (hs)           e_dat  = vdata;
    if (hs && !weight) e_vdst = nvdst;
    case (ph)
      0: if (hs && weight) begin wc++; if (wc == WROWS) begin wc = 0; ph = 1; end end
      1: if (valid && weight) ph = 2;
      default: if (tsz == 0) ph = 0;
    endcase
    @(posedge CLK);
    last_hs = hs;
    @(negedge CLK);
  endtask

  task automatic drv(input bit v, input bit w, input logic [TAGW-1:0] t,
                     input bit oe, input bit ordy, input bit fhs);
    if (!(valid && !last_hs)) vdata = rnd_vec();
    valid = v; weight = w; nvdst = t;
    out_en = oe; output_ready = ordy; fifo_has_space = fhs;
    array_output = rnd_vec();
    step();
  endtask

  task automatic offer(input bit w, input logic [TAGW-1:0] t, input bit ordy, input int maxc);
    int k = 0;
    do begin
      drv(1'b1, w, t, 1'b0, ordy, 1'b1);
      k++;
    end while (!last_hs && k < maxc);
    chk("offer_accepted", DW'(last_hs), DW'(1));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    model_reset();
    #1;
    check_outs(1'b1);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b1; vdata = '0; valid = 1'b1; weight = 1'b1; nvdst = '0;
    array_output = '0; out_en = 1'b0; fifo_has_space = 1'b1; output_ready = 1'b0;
    model_reset();

    // Reset with a weight offered: ready=1, everything else 0.
    do_reset();

    // Four weight rows, then first activation tag 3.
    repeat (WROWS) drv(1, 1, 0, 0, 0, 1);
    drv(1, 0, 8'd3, 0, 0, 1);

    // Fill credit with 7, 9, 12 and hold a fifth; return four results; then write back.
    drv(1, 0, 8'd7, 0, 0, 1);
    drv(1, 0, 8'd9, 0, 0, 1);
    drv(1, 0, 8'd12, 0, 0, 1);
    repeat (2) drv(1, 0, 8'd5, 0, 0, 1);
    repeat (4) drv(1, 0, 8'd5, 1, 0, 1);
    offer(0, 8'd5, 1, 10);
    valid = 0;
    repeat (4) drv(0, 0, 0, 0, 1, 1);

    // Two in flight (5, 6), weight offered -> drain, then reload.
    offer(0, 8'd6, 1, 5);
    repeat (3) drv(1, 1, 0, 0, 1, 1);
    repeat (2) drv(1, 1, 0, 1, 1, 1);
    offer(1, 0, 1, 5);
    repeat (WROWS-1) offer(1, 0, 1, 3);

    // Array input FIFO full holds activations off; space releases it the same cycle.
    repeat (3) drv(1, 0, 8'd8, 0, 1, 0);
    offer(0, 8'd8, 1, 1);
    drv(0, 0, 0, 1, 1, 1);
    repeat (2) drv(0, 0, 0, 0, 1, 1);

    // Spurious out_en: sticky err, nothing buffered; reset clears it.
    drv(0, 0, 0, 1, 1, 1);
    repeat (3) drv(0, 0, 0, 0, 1, 1);
    valid = 1; weight = 1;
    do_reset();

    // Random traffic with a reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      bit v, w, oe;
      logic [TAGW-1:0] t;
      if (c == 1500) do_reset();
      if (valid && !last_hs) begin
        v = valid; w = weight; t = nvdst;
      end else begin
        v = ($urandom_range(3) != 0);
        w = (ph == 0) ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
        t = TAGW'($urandom);
      end
      oe = (tq.size() != 0) ? ($urandom_range(2) == 0) : ($urandom_range(400) == 0);
      drv(v, w, t, oe, $urandom_range(1) == 1, $urandom_range(4) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
